// File: rtl/player_cmd_ctrl_pkg.sv
// Shared types for the blackjack player command path: command codes seen by
// the game FSM and the state encoding of the command controller.
package bj_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_HIT   = 2'b01,
        CMD_STAY  = 2'b10,
        CMD_START = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_VALID   = 2'b01,
        S_LOCKOUT = 2'b10
    } state_t;

endpackage : bj_pkg

// File: rtl/player_cmd_ctrl_edge_rise.sv
// Single-bit rising-edge detector. The previous level resets to 1 so that a
// button already held when reset releases is not mistaken for a fresh press.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    // Next value of the history flop is simply the current level.
    always_comb begin
        prev_d = d;
    end

    // History flop, preset to 1 on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;

endmodule : edge_rise

// File: rtl/player_cmd_ctrl.sv
// Turns debounced hit/stay/start levels into one arbitrated command held on a
// valid/ready handshake, followed by a lockout window. Presses that arrive
// while a command is pending or locked out are counted as drops.
module player_cmd_ctrl
    import bj_pkg::*;
#(
    parameter int LOCKOUT_CYC = 1_000_000,
    parameter int DROP_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hit_db,
    input  logic              stay_db,
    input  logic              start_db,
    input  logic              cmd_ready,
    input  logic              drop_clr,
    output logic              cmd_valid,
    output logic [1:0]        cmd,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    // Lockout counter is sized to hold LOCKOUT_CYC-1, never narrower than 1 bit.
    localparam int                CNT_W    = (LOCKOUT_CYC < 1) ? 1 : $clog2(LOCKOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'((LOCKOUT_CYC > 0) ? (LOCKOUT_CYC - 1) : 0);
    localparam bit                LOCK_EN  = (LOCKOUT_CYC > 0);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic hit_rise;
    logic stay_rise;
    logic start_rise;
    logic any_rise;
    cmd_t sel_cmd;
    logic drop_ev;

    state_t              state_q,     state_d;
    cmd_t                cmd_q,       cmd_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [DROP_W-1:0]   drop_q,      drop_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                busy_q,      busy_d;

    edge_rise u_hit_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (hit_db),
        .rise  (hit_rise)
    );

    edge_rise u_stay_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (stay_db),
        .rise  (stay_rise)
    );

    edge_rise u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (start_db),
        .rise  (start_rise)
    );

    // Priority select among coincident presses: start, then stay, then hit.
    always_comb begin
        any_rise = hit_rise | stay_rise | start_rise;
        if (start_rise) begin
            sel_cmd = CMD_START;
        end else if (stay_rise) begin
            sel_cmd = CMD_STAY;
        end else if (hit_rise) begin
            sel_cmd = CMD_HIT;
        end else begin
            sel_cmd = CMD_NONE;
        end
    end

    // Controller next-state, command hold and lockout countdown.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (any_rise) begin
                    state_d = S_VALID;
                    cmd_d   = sel_cmd;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_VALID: begin
                if (cmd_ready) begin
                    cmd_d = CMD_NONE;
                    if (LOCK_EN) begin
                        state_d = S_LOCKOUT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_VALID;
                end
            end
            S_LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cmd_d   = CMD_NONE;
                cnt_d   = '0;
            end
        endcase
        cmd_valid_d = (state_d == S_VALID);
        busy_d      = (state_d != S_IDLE);
    end

    // Saturating drop counter; clear takes precedence over a same-cycle drop.
    always_comb begin
        drop_ev = any_rise && (state_q != S_IDLE);
        if (drop_clr) begin
            drop_d = '0;
        end else if (drop_ev && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + DROP_W'(1);
        end else begin
            drop_d = drop_q;
        end
    end

    // State, command, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= CMD_NONE;
            cnt_q       <= '0;
            drop_q      <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign busy      = busy_q;
    assign drop_cnt  = drop_q;

endmodule : player_cmd_ctrl

// File: tb/tb_player_cmd_ctrl.sv
// Bench for player_cmd_ctrl. Two instances share the stimulus: A has a
// 4-cycle lockout and a 2-bit drop counter, B has no lockout and an 8-bit
// drop counter. Both are compared every cycle against a behavioural model.
module tb_player_cmd_ctrl;
    import bj_pkg::*;

    logic clk;
    logic rst_n;
    logic hit_db, stay_db, start_db, cmd_ready, drop_clr;

    logic       a_valid, a_busy;
    logic [1:0] a_cmd, a_drop;
    logic       b_valid, b_busy;
    logic [1:0] b_cmd;
    logic [7:0] b_drop;

    int n_run;
    int n_fail;

    player_cmd_ctrl #(.LOCKOUT_CYC(4), .DROP_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .hit_db(hit_db), .stay_db(stay_db),
        .start_db(start_db), .cmd_ready(cmd_ready), .drop_clr(drop_clr),
        .cmd_valid(a_valid), .cmd(a_cmd), .busy(a_busy), .drop_cnt(a_drop)
    );

    player_cmd_ctrl #(.LOCKOUT_CYC(0), .DROP_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .hit_db(hit_db), .stay_db(stay_db),
        .start_db(start_db), .cmd_ready(cmd_ready), .drop_clr(drop_clr),
        .cmd_valid(b_valid), .cmd(b_cmd), .busy(b_busy), .drop_cnt(b_drop)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // Per instance: levels last seen, whether a command is waiting, which one,
    // how many lockout cycles remain, and how many presses were lost.
    logic [2:0] m_prev [2];
    bit         m_pend [2];
    logic [1:0] m_cmd  [2];
    int         m_lock [2];
    int         m_drop [2];

    function automatic int lock_len(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic int drop_max(input int k);
        return (k == 0) ? 3 : 255;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_prev[k] = 3'b111;
            m_pend[k] = 1'b0;
            m_cmd[k]  = CMD_NONE;
            m_lock[k] = 0;
            m_drop[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        logic [2:0] lv;
        logic [2:0] pressed;
        bit         engaged;
        lv        = {start_db, stay_db, hit_db};
        pressed   = lv & ~m_prev[k];
        m_prev[k] = lv;
        engaged   = m_pend[k] || (m_lock[k] > 0);
        if (drop_clr) m_drop[k] = 0;
        else if ((pressed != 3'b000) && engaged && (m_drop[k] < drop_max(k))) m_drop[k]++;
        if (m_pend[k]) begin
            if (cmd_ready) begin
                m_pend[k] = 1'b0;
                m_cmd[k]  = CMD_NONE;
                m_lock[k] = lock_len(k);
            end
        end else if (m_lock[k] > 0) begin
            m_lock[k]--;
        end else if (pressed != 3'b000) begin
            m_pend[k] = 1'b1;
            m_cmd[k]  = pressed[2] ? CMD_START : (pressed[1] ? CMD_STAY : CMD_HIT);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic compare_all();
        chk("A.cmd_valid", 32'(a_valid), 32'(m_pend[0]));
        chk("A.cmd",       32'(a_cmd),   32'(m_cmd[0]));
        chk("A.busy",      32'(a_busy),  32'(m_pend[0] || (m_lock[0] > 0)));
        chk("A.drop_cnt",  32'(a_drop),  32'(m_drop[0]));
        chk("B.cmd_valid", 32'(b_valid), 32'(m_pend[1]));
        chk("B.cmd",       32'(b_cmd),   32'(m_cmd[1]));
        chk("B.busy",      32'(b_busy),  32'(m_pend[1] || (m_lock[1] > 0)));
        chk("B.drop_cnt",  32'(b_drop),  32'(m_drop[1]));
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic cycle(input logic h, input logic s, input logic st,
                         input logic rdy, input logic clr);
        hit_db = h; stay_db = s; start_db = st; cmd_ready = rdy; drop_clr = clr;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic       h, s, st, rdy, clr;
        logic       v;
        logic [1:0] c;
        logic       b;
        logic [1:0] d;
    } vec_t;

    vec_t tv [15];

    initial begin
        int  busy_run;
        int  busy_max;
        logic [1:0] cmd_seen;
        bit  cmd_stable;

        n_run = 0;
        n_fail = 0;

        //          h     s     st    rdy   clr   v     c      b     d
        tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 2'd0};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd0};
        tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd0};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd0};
        tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd0};
        tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0};
        tv[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 2'd0};
        tv[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd0};
        tv[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd0};
        tv[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd0};
        tv[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'd0};
        tv[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0};
        tv[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0};

        // Reset with all buttons pressed: nothing may fire after release.
        rst_n = 1'b0;
        hit_db = 1'b1; stay_db = 1'b1; start_db = 1'b1; cmd_ready = 1'b1; drop_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("held_through_reset_no_cmd", 32'(a_valid | b_valid), 32'd0);

        for (int i = 0; i < 15; i++) begin
            cycle(tv[i].h, tv[i].s, tv[i].st, tv[i].rdy, tv[i].clr);
            chk($sformatf("table[%0d].cmd_valid", i), 32'(a_valid), 32'(tv[i].v));
            chk($sformatf("table[%0d].cmd", i),       32'(a_cmd),   32'(tv[i].c));
            chk($sformatf("table[%0d].busy", i),      32'(a_busy),  32'(tv[i].b));
            chk($sformatf("table[%0d].drop_cnt", i),  32'(a_drop),  32'(tv[i].d));
        end

        // Back-pressure: stay pending for 20 cycles, two hit presses dropped.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd_stable = 1'b1;
        for (int j = 0; j < 20; j++) begin
            cycle((j == 3) || (j == 7), 1'b1, 1'b0, 1'b0, 1'b0);
            if (!(a_valid === 1'b1 && a_cmd === 2'b10)) cmd_stable = 1'b0;
        end
        chk("backpressure_cmd_held", 32'(cmd_stable), 32'd1);
        chk("backpressure_drops", 32'(a_drop), 32'd2);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("backpressure_transfer_valid", 32'(a_valid), 32'd0);
        chk("backpressure_transfer_busy", 32'(a_busy), 32'd1);

        // Saturation of the 2-bit counter, then clear racing a drop.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("drop_saturated", 32'(a_drop), 32'd3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("drop_clr_wins", 32'(a_drop), 32'd0);

        // Reset while a hit command is pending and the button is held.
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_valid", 32'(a_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(a_valid), 32'd0);
        chk("async_reset_cmd",   32'(a_cmd),   32'd0);
        chk("async_reset_busy",  32'(a_busy),  32'd0);
        chk("async_reset_drop_b", 32'(b_drop), 32'd0);
        model_reset();
        @(posedge clk);
        #4 rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("held_after_reset_no_cmd", 32'(a_valid), 32'd0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("repress_valid", 32'(a_valid), 32'd1);
        chk("repress_cmd",   32'(a_cmd),   32'd1);

        // Zero lockout on B: hit presses every 2 cycles each give a command.
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        busy_run = 0;
        busy_max = 0;
        for (int j = 0; j < 12; j++) begin
            cycle((j % 2) == 0, 1'b0, 1'b0, 1'b1, 1'b0);
            busy_run = b_busy ? busy_run + 1 : 0;
            if (busy_run > busy_max) busy_max = busy_run;
            if ((j % 2) == 0) begin
                chk("zero_lock_cmd", 32'({b_valid, b_cmd}), 32'({1'b1, 2'b01}));
            end else begin
                chk("zero_lock_idle", 32'({b_valid, b_busy}), 32'd0);
            end
        end
        chk("zero_lock_busy_run", 32'(busy_max), 32'd1);

        // Random traffic against the model.
        cmd_seen = 2'b00;
        for (int j = 0; j < 3000; j++) begin
            logic h, s, st;
            h  = ($urandom_range(0, 3) == 0) ? ~hit_db   : hit_db;
            s  = ($urandom_range(0, 5) == 0) ? ~stay_db  : stay_db;
            st = ($urandom_range(0, 7) == 0) ? ~start_db : start_db;
            cycle(h, s, st, 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
            if (a_valid) cmd_seen = a_cmd;
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_player_cmd_ctrl
